// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default field widths, ALU NOP code
// and the packed control bundle carried by the stage registers.
//
// Contents:
//   DATA_W, REGA_W, ALUOP_W  default widths
//   ALUOP_NOP                ALU operation code of a bubble
//   ctrl_t                   1-bit control flags of one instruction
//   CTRL_NOP                 all-zero control bundle
package pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int REGA_W  = 5;
    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP = '0;

    typedef struct packed {
        logic JtoPC;
        logic Branch;
        logic RegWrite;
        logic ALUSrc;
        logic MemWrite;
        logic MemRead;
        logic MemtoReg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter: counts inc pulses on the falling clock
// edge and sticks at its all-ones maximum.
//
// Ports:
//   clk  in   stage clock (state updates on the falling edge)
//   rst  in   asynchronous active-high reset, clears the count
//   inc  in   count this edge
//   cnt  out  W-bit count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register, updated on the falling edge of CLK.
// Priority: flush (bubble) > stall (hold) > load.
//
// Ports:
//   CLK, RST                      clock, async active-high reset
//   stall, flush                  hazard controls
//   valid_in / valid_out          slot holds a real instruction
//   Wreg_addr, imm, Rdata1,
//   Rdata2, next_PC (_in/_out)    data fields
//   JtoPC, Branch, RegWrite,
//   ALUSrc, MemWrite, MemRead,
//   MemtoReg, ALUOp (_in/_out)    control fields
//   bubble_cnt                    saturating count of flushes
//                                 (only with ID_EX_BUBBLE_CNT_EN)
module id_ex_stage_reg #(
    parameter int DATA_W  = pipe_pkg::DATA_W,
    parameter int REGA_W  = pipe_pkg::REGA_W,
    parameter int ALUOP_W = pipe_pkg::ALUOP_W
`ifdef ID_EX_BUBBLE_CNT_EN
   ,parameter int CNT_W   = 16
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [REGA_W-1:0]  Wreg_addr_in,
    input  logic [DATA_W-1:0]  imm_in,
    input  logic [DATA_W-1:0]  Rdata1_in,
    input  logic [DATA_W-1:0]  Rdata2_in,
    input  logic [DATA_W-1:0]  next_PC_in,
    input  logic               JtoPC_in,
    input  logic               Branch_in,
    input  logic               RegWrite_in,
    input  logic               ALUSrc_in,
    input  logic               MemWrite_in,
    input  logic               MemRead_in,
    input  logic               MemtoReg_in,
    input  logic [ALUOP_W-1:0] ALUOp_in,
    output logic               valid_out,
    output logic [REGA_W-1:0]  Wreg_addr_out,
    output logic [DATA_W-1:0]  imm_out,
    output logic [DATA_W-1:0]  Rdata1_out,
    output logic [DATA_W-1:0]  Rdata2_out,
    output logic [DATA_W-1:0]  next_PC_out,
    output logic               JtoPC_out,
    output logic               Branch_out,
    output logic               RegWrite_out,
    output logic               ALUSrc_out,
    output logic               MemWrite_out,
    output logic               MemRead_out,
    output logic               MemtoReg_out,
    output logic [ALUOP_W-1:0] ALUOp_out
`ifdef ID_EX_BUBBLE_CNT_EN
   ,output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    import pipe_pkg::*;

    localparam logic [ALUOP_W-1:0] W_NOP = ALUOP_W'(ALUOP_NOP);

    ctrl_t               w_ctrl_in;
    ctrl_t               r_ctrl;
    logic                r_valid;
    logic [ALUOP_W-1:0]  r_aluop;
    logic [REGA_W-1:0]   r_wreg;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_rd1;
    logic [DATA_W-1:0]   r_rd2;
    logic [DATA_W-1:0]   r_npc;

    assign w_ctrl_in = '{
        JtoPC:    JtoPC_in,
        Branch:   Branch_in,
        RegWrite: RegWrite_in,
        ALUSrc:   ALUSrc_in,
        MemWrite: MemWrite_in,
        MemRead:  MemRead_in,
        MemtoReg: MemtoReg_in
    };

    // Data fields pass through even on a bubble; only the
    // controls and valid are squashed.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_aluop <= '0;
            r_wreg  <= '0;
            r_imm   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_npc   <= '0;
        end else if (flush || !stall) begin
            r_valid <= valid_in && !flush;
            // An invalid slot is squashed like a bubble.
            r_ctrl  <= (valid_in && !flush) ? w_ctrl_in : CTRL_NOP;
            r_aluop <= (valid_in && !flush) ? ALUOp_in : W_NOP;
            r_wreg  <= Wreg_addr_in;
            r_imm   <= imm_in;
            r_rd1   <= Rdata1_in;
            r_rd2   <= Rdata2_in;
            r_npc   <= next_PC_in;
        end
    end

    assign valid_out     = r_valid;
    assign Wreg_addr_out = r_wreg;
    assign imm_out       = r_imm;
    assign Rdata1_out    = r_rd1;
    assign Rdata2_out    = r_rd2;
    assign next_PC_out   = r_npc;
    assign JtoPC_out     = r_ctrl.JtoPC;
    assign Branch_out    = r_ctrl.Branch;
    assign RegWrite_out  = r_ctrl.RegWrite;
    assign ALUSrc_out    = r_ctrl.ALUSrc;
    assign MemWrite_out  = r_ctrl.MemWrite;
    assign MemRead_out   = r_ctrl.MemRead;
    assign MemtoReg_out  = r_ctrl.MemtoReg;
    assign ALUOp_out     = r_aluop;

`ifdef ID_EX_BUBBLE_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk(CLK),
        .rst(RST),
        .inc(flush),
        .cnt(bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table,
// reset corner cases and random traffic against a reference model.
module tb_id_ex_stage_reg;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [6:0]  ctrl;
        logic [3:0]  aluop;
        logic [4:0]  wreg;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] npc;
    } in_t;

    typedef struct {
        in_t         i;
        logic        e_valid;
        logic [6:0]  e_ctrl;
        logic [3:0]  e_aluop;
        logic [31:0] e_imm;
        logic [31:0] e_rd1;
        int          e_cnt;
    } vec_t;

    logic CLK = 1'b1;
    logic RST = 1'b1;
    in_t  cur;

    logic        valid_out;
    logic [4:0]  Wreg_addr_out;
    logic [31:0] imm_out, Rdata1_out, Rdata2_out, next_PC_out;
    logic        JtoPC_out, Branch_out, RegWrite_out, ALUSrc_out;
    logic        MemWrite_out, MemRead_out, MemtoReg_out;
    logic [3:0]  ALUOp_out;
    logic [6:0]  act_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CW-1:0] bubble_cnt;
`endif

    always #5 CLK = ~CLK;

    id_ex_stage_reg #(
        .DATA_W(32), .REGA_W(5), .ALUOP_W(4)
`ifdef ID_EX_BUBBLE_CNT_EN
       ,.CNT_W(CW)
`endif
    ) dut (
        .CLK(CLK), .RST(RST),
        .stall(cur.stall), .flush(cur.flush),
        .valid_in(cur.valid),
        .Wreg_addr_in(cur.wreg), .imm_in(cur.imm),
        .Rdata1_in(cur.rd1), .Rdata2_in(cur.rd2),
        .next_PC_in(cur.npc),
        .JtoPC_in(cur.ctrl[6]), .Branch_in(cur.ctrl[5]),
        .RegWrite_in(cur.ctrl[4]), .ALUSrc_in(cur.ctrl[3]),
        .MemWrite_in(cur.ctrl[2]), .MemRead_in(cur.ctrl[1]),
        .MemtoReg_in(cur.ctrl[0]), .ALUOp_in(cur.aluop),
        .valid_out(valid_out), .Wreg_addr_out(Wreg_addr_out),
        .imm_out(imm_out), .Rdata1_out(Rdata1_out),
        .Rdata2_out(Rdata2_out), .next_PC_out(next_PC_out),
        .JtoPC_out(JtoPC_out), .Branch_out(Branch_out),
        .RegWrite_out(RegWrite_out), .ALUSrc_out(ALUSrc_out),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out),
        .MemtoReg_out(MemtoReg_out), .ALUOp_out(ALUOp_out)
`ifdef ID_EX_BUBBLE_CNT_EN
       ,.bubble_cnt(bubble_cnt)
`endif
    );

    assign act_ctrl = {JtoPC_out, Branch_out, RegWrite_out, ALUSrc_out,
                       MemWrite_out, MemRead_out, MemtoReg_out};

    int total = 0;
    int bad   = 0;

    // Reference: what the stage should hold after each edge.
    logic        m_valid;
    logic [6:0]  m_ctrl;
    logic [3:0]  m_aluop;
    logic [4:0]  m_wreg;
    logic [31:0] m_imm, m_rd1, m_rd2, m_npc;
    int          m_cnt;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ctrl = 0; m_aluop = 0; m_wreg = 0;
        m_imm = 0; m_rd1 = 0; m_rd2 = 0; m_npc = 0; m_cnt = 0;
    endtask

    // A slot becomes a live instruction only when loaded, valid and
    // not flushed; data words always follow the input unless held.
    task automatic model_edge();
        bit live;
        if (cur.flush) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        if (cur.stall && !cur.flush) return;
        live    = cur.valid && !cur.flush;
        m_valid = live;
        m_ctrl  = live ? cur.ctrl : 7'd0;
        m_aluop = live ? cur.aluop : 4'd0;
        m_wreg  = cur.wreg;
        m_imm   = cur.imm;
        m_rd1   = cur.rd1;
        m_rd2   = cur.rd2;
        m_npc   = cur.npc;
    endtask

    task automatic check_model(string t);
        chk({t, ".valid"}, 64'(valid_out), 64'(m_valid));
        chk({t, ".ctrl"}, 64'(act_ctrl), 64'(m_ctrl));
        chk({t, ".aluop"}, 64'(ALUOp_out), 64'(m_aluop));
        chk({t, ".wreg"}, 64'(Wreg_addr_out), 64'(m_wreg));
        chk({t, ".imm"}, 64'(imm_out), 64'(m_imm));
        chk({t, ".rd1"}, 64'(Rdata1_out), 64'(m_rd1));
        chk({t, ".rd2"}, 64'(Rdata2_out), 64'(m_rd2));
        chk({t, ".npc"}, 64'(next_PC_out), 64'(m_npc));
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({t, ".cnt"}, 64'(bubble_cnt), 64'(m_cnt));
`endif
    endtask

    task automatic check_zero(string t);
        chk({t, ".valid"}, 64'(valid_out), 64'd0);
        chk({t, ".ctrl"}, 64'(act_ctrl), 64'd0);
        chk({t, ".aluop"}, 64'(ALUOp_out), 64'd0);
        chk({t, ".data"}, {Rdata1_out, imm_out}, 64'd0);
        chk({t, ".data2"}, {Rdata2_out, next_PC_out}, 64'd0);
        chk({t, ".wreg"}, 64'(Wreg_addr_out), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({t, ".cnt"}, 64'(bubble_cnt), 64'd0);
`endif
    endtask

    // Inputs change just after the rising edge; the DUT acts on the
    // falling edge and is sampled at the next rising edge.
    task automatic step();
        @(negedge CLK);
        model_edge();
        @(posedge CLK);
    endtask

    function automatic in_t rnd_in();
        in_t v;
        v.stall = ($urandom_range(3) == 0);
        v.flush = ($urandom_range(4) == 0);
        v.valid = ($urandom_range(3) != 0);
        v.ctrl  = 7'($urandom);
        v.aluop = 4'($urandom);
        v.wreg  = 5'($urandom);
        v.imm   = $urandom;
        v.rd1   = $urandom;
        v.rd2   = $urandom;
        v.npc   = $urandom;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        tbl[0] = '{'{0,0,1,7'b0010000,4'h2,5'd3,32'h0000_1234,32'h0,32'h1,32'h100},
                   1, 7'b0010000, 4'h2, 32'h0000_1234, 32'h0, 0};
        tbl[1] = '{'{1,0,0,7'h7f,4'h7,5'd9,32'hFFFF_FFFF,32'h55,32'h2,32'h200},
                   1, 7'b0010000, 4'h2, 32'h0000_1234, 32'h0, 0};
        tbl[2] = '{'{1,0,1,7'h15,4'h9,5'd1,32'hA5A5_A5A5,32'h66,32'h3,32'h300},
                   1, 7'b0010000, 4'h2, 32'h0000_1234, 32'h0, 0};
        tbl[3] = '{'{1,0,0,7'h2a,4'hC,5'd2,32'h5A5A_5A5A,32'h77,32'h4,32'h400},
                   1, 7'b0010000, 4'h2, 32'h0000_1234, 32'h0, 0};
        tbl[4] = '{'{1,1,1,7'b0010100,4'h5,5'd7,32'h0,32'hDEAD_BEEF,32'h5,32'h500},
                   0, 7'd0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1};
        tbl[5] = '{'{0,0,0,7'b0100000,4'h3,5'd8,32'h42,32'h11,32'h6,32'h600},
                   0, 7'd0, 4'h0, 32'h42, 32'h11, 1};
        tbl[6] = '{'{0,0,1,7'b1000001,4'hF,5'd31,32'h7,32'h8,32'h7,32'h700},
                   1, 7'b1000001, 4'hF, 32'h7, 32'h8, 1};

        // Reset with every input nonzero, before any clock edge.
        cur = '{1,1,1,7'h7f,4'hF,5'h1f,'1,'1,'1,'1};
        model_reset();
        #2;
        check_zero("rst_async");

        @(posedge CLK);
        RST = 1'b0;

        foreach (tbl[k]) begin
            cur = tbl[k].i;
            step();
            chk($sformatf("tbl%0d.valid", k), 64'(valid_out), 64'(tbl[k].e_valid));
            chk($sformatf("tbl%0d.ctrl", k), 64'(act_ctrl), 64'(tbl[k].e_ctrl));
            chk($sformatf("tbl%0d.aluop", k), 64'(ALUOp_out), 64'(tbl[k].e_aluop));
            chk($sformatf("tbl%0d.imm", k), 64'(imm_out), 64'(tbl[k].e_imm));
            chk($sformatf("tbl%0d.rd1", k), 64'(Rdata1_out), 64'(tbl[k].e_rd1));
`ifdef ID_EX_BUBBLE_CNT_EN
            chk($sformatf("tbl%0d.cnt", k), 64'(bubble_cnt), 64'(tbl[k].e_cnt));
`endif
            check_model($sformatf("tbl%0d.m", k));
        end

        // Reset asserted between falling edges while stalled.
        cur = '{1,0,1,7'h3c,4'h6,5'd12,32'h1111,32'h2222,32'h3333,32'h4444};
        step();
        #2;
        RST = 1'b1;
        #1;
        check_zero("rst_stall");
        model_reset();
        #1;
        RST = 1'b0;
        cur = '{1,0,1,7'h41,4'hA,5'd5,32'hCAFE,32'hBEEF,32'hF00D,32'h1000};
        cur.stall = 1'b0;
        step();
        chk("rst_release.imm", 64'(imm_out), 64'hCAFE);
        chk("rst_release.ctrl", 64'(act_ctrl), 64'h41);
        check_model("rst_release");

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            cur = rnd_in();
            step();
            check_model($sformatf("rnd%0d", n));
        end

        // Counter saturation over 20 consecutive flushes.
        RST = 1'b1;
        #1;
        model_reset();
        check_zero("rst_sat");
        RST = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cur = rnd_in();
            cur.flush = 1'b1;
            step();
`ifdef ID_EX_BUBBLE_CNT_EN
            if (n == 14 || n == 19)
                chk($sformatf("sat%0d.cnt", n), 64'(bubble_cnt),
                    64'((n + 1 > CMAX) ? CMAX : n + 1));
`endif
            chk($sformatf("sat%0d.valid", n), 64'(valid_out), 64'd0);
        end
        check_model("sat_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
